bias_add_ctrl: RTL
==================

BIAS_ADD_CTRL -- requirements
Module: bias_add_ctrl

Interface
REQ-001 SHALL have parameter: LANES, 8, number of per-lane bias registers (2..16, power of two).
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: bias_wr_en  in  1  bias register write strobe.
REQ-005 SHALL have port: bias_wr_addr  in  log2(LANES)  bias register index.
REQ-006 SHALL have port: bias_wr_data  in  32  FP32 bias value.
REQ-007 SHALL have ports: psum_valid in 1, psum_ready out 1, psum_data in 32, psum_last in 1; this is the FP32 partial-sum input stream.
REQ-008 SHALL have ports: res_valid out 1, res_ready in 1, res_data out 32, res_last out 1; this is the biased result stream.
REQ-009 SHALL have adder-side ports: add_a out 32, add_a_stb out 1, add_a_ack in 1, add_b out 32, add_b_stb out 1, add_b_ack in 1, add_z in 32, add_z_stb in 1, add_z_ack out 1.
REQ-010 SHALL have status ports: busy out 1 (state != IDLE), elem_cnt out 16 (results delivered), nan_seen out 1 (sticky), nan_clr in 1.

Function
REQ-011 SHALL implement the FSM states IDLE, SEND_A, SEND_B, WAIT_Z and OUT, all transitions occurring on the rising clk edge.
REQ-012 In IDLE, psum_ready SHALL be 1; on psum_valid&&psum_ready the block SHALL latch add_a=psum_data, add_b=bias[lane], and last=psum_last, then go to SEND_A.
REQ-013 In every other state, psum_ready SHALL be 0, allowing one element in flight.
REQ-014 add_a_stb SHALL equal (state==SEND_A); on add_a_stb&&add_a_ack the FSM SHALL go to SEND_B.
REQ-015 add_b_stb SHALL equal (state==SEND_B); on add_b_stb&&add_b_ack the FSM SHALL go to WAIT_Z.
REQ-016 add_z_ack SHALL equal (state==WAIT_Z); on add_z_stb&&add_z_ack the block SHALL register add_z into res_data and go to OUT.
REQ-017 In OUT, res_valid SHALL be 1; res_data and res_last SHALL stay stable until res_ready; on res_valid&&res_ready the FSM SHALL return to IDLE.
REQ-018 The lane index SHALL advance on each res handshake, wrapping from LANES-1 to 0, and SHALL return to 0 after a handshake with res_last=1.
REQ-019 Bias is sampled at psum acceptance; a bias write to the same address in the same cycle SHALL NOT affect the accepted element (old value used).
REQ-020 Bias writes SHALL be accepted in any state, with no stall.
REQ-021 elem_cnt SHALL increment on each res handshake and wrap 0xFFFF->0x0000.
REQ-022 nan_seen SHALL set when a captured add_z has exponent 0xFF and a nonzero mantissa; nan_clr SHALL clear it, and a simultaneous set takes priority over clear.
REQ-023 With zero wait states on every handshake, psum acceptance to res_valid SHALL take 3 controller cycles plus the adder's compute time.
REQ-024 The adder stb/ack handshakes SHALL tolerate arbitrary ack/stb delay; no timeout is required.

Reset
REQ-025 On rst, the block SHALL immediately enter IDLE, with lane=0, elem_cnt=0, nan_seen=0 and all bias registers=0x00000000.
REQ-026 During rst, the outputs SHALL be: res_valid=0, res_data=0, res_last=0, add_a=add_b=0, all stb/ack outputs=0, busy=0 and psum_ready=0; psum_ready SHALL become 1 on the first clk edge after rst deasserts.
REQ-027 Reset in any non-IDLE state SHALL discard the in-flight element without emitting a result; the adder SHALL be reset by the same rst.

Configuration
REQ-028 When the macro BIAS_ADD_CTRL_RELU_EN is defined, a result with sign=1 SHALL be replaced by 0x00000000 at capture, except NaN values, which SHALL pass unchanged.
REQ-029 When BIAS_ADD_CTRL_RELU_EN is undefined, the captured add_z SHALL pass unmodified.
REQ-030 nan_seen detection SHALL be identical in both configurations.

Verification
REQ-031 Bias[0]=0x40000000, psum 0x3F800000 -> res_data=0x40400000, res_last as driven, elem_cnt=1.
REQ-032 LANES=4, bias[i]=i+1.0, five psums of 0x00000000 -> results 1.0, 2.0, 3.0, 4.0, 1.0 (lane wrap); psum_last on the 2nd element -> the 3rd element uses bias[0].
REQ-033 Psum 0xC0400000 plus bias 0x3F800000 -> 0xC0000000 without the macro and 0x00000000 with BIAS_ADD_CTRL_RELU_EN.
REQ-034 Hold res_ready=0 for 10 cycles in OUT -> res_data is stable, psum_ready=0 and elem_cnt is unchanged; release -> exactly one handshake occurs.
REQ-035 Psum 0x7FC00000 -> nan_seen=1, which persists until nan_clr; nan_clr asserted in the same cycle as a new NaN capture -> nan_seen stays 1.
REQ-036 Assert rst in WAIT_Z -> busy=0 and res_valid never asserts for that element; the next psum after reset uses lane 0 with bias 0x00000000.

Source files
------------

// File: rtl/bias_add_ctrl.sv
// bias_add_ctrl: per-lane FP32 bias-add sequencer.
// Accepts one partial sum at a time, pairs it with the bias of the current
// lane, and drives an external FP32 adder over stb/ack handshakes. The
// adder's sum is presented on a valid/ready result stream.
// Optional build macro BIAS_ADD_CTRL_RELU_EN zeroes negative non-NaN results
// at capture. Without the macro, results pass through unmodified.
module bias_add_ctrl #(
  parameter  int LANES = 8,
  localparam int LW    = $clog2(LANES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bias_wr_en,
  input  logic [LW-1:0] bias_wr_addr,
  input  logic [31:0]   bias_wr_data,
  input  logic          psum_valid,
  output logic          psum_ready,
  input  logic [31:0]   psum_data,
  input  logic          psum_last,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   res_data,
  output logic          res_last,
  output logic [31:0]   add_a,
  output logic          add_a_stb,
  input  logic          add_a_ack,
  output logic [31:0]   add_b,
  output logic          add_b_stb,
  input  logic          add_b_ack,
  input  logic [31:0]   add_z,
  input  logic          add_z_stb,
  output logic          add_z_ack,
  output logic          busy,
  output logic [15:0]   elem_cnt,
  output logic          nan_seen,
  input  logic          nan_clr
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SEND_A = 3'd1;
  localparam logic [2:0] SEND_B = 3'd2;
  localparam logic [2:0] WAIT_Z = 3'd3;
  localparam logic [2:0] OUT    = 3'd4;

  localparam logic [LW-1:0] LANE_ZERO = LW'(0);
  localparam logic [LW-1:0] LANE_ONE  = LW'(1);

  logic [2:0]    r_state;
  logic [LW-1:0] r_lane;
  logic [31:0]   r_bias [LANES];
  logic [31:0]   r_add_a;
  logic [31:0]   r_add_b;
  logic          r_last;
  logic [31:0]   r_res_data;
  logic [15:0]   r_elem_cnt;
  logic          r_nan_seen;
  logic          r_psum_ready;
  logic          r_a_stb;
  logic          r_b_stb;
  logic          r_z_ack;
  logic          r_res_valid;
  logic          r_busy;

  logic [2:0]    w_state_nxt;
  logic          w_psum_hs;
  logic          w_a_hs;
  logic          w_b_hs;
  logic          w_z_hs;
  logic          w_res_hs;
  logic          w_z_nan;
  logic [31:0]   w_z_cap;

  assign w_psum_hs = psum_valid & r_psum_ready;
  assign w_a_hs    = r_a_stb & add_a_ack;
  assign w_b_hs    = r_b_stb & add_b_ack;
  assign w_z_hs    = r_z_ack & add_z_stb;
  assign w_res_hs  = r_res_valid & res_ready;

  // NaN: all-ones exponent with a nonzero mantissa (checked on the raw sum).
  assign w_z_nan = (add_z[30:23] == 8'hFF) && (add_z[22:0] != 23'd0);

  // Value actually stored into the result register when the adder answers.
  always_comb begin
    w_z_cap = add_z;
`ifdef BIAS_ADD_CTRL_RELU_EN
    if (add_z[31] && !w_z_nan) begin
      w_z_cap = 32'h0000_0000;
    end else begin
      w_z_cap = add_z;
    end
`else
    w_z_cap = add_z;
`endif
  end

  // Next-state logic: one element in flight, each step waits on its handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_psum_hs) w_state_nxt = SEND_A; else w_state_nxt = IDLE;
      SEND_A:  if (w_a_hs)    w_state_nxt = SEND_B; else w_state_nxt = SEND_A;
      SEND_B:  if (w_b_hs)    w_state_nxt = WAIT_Z; else w_state_nxt = SEND_B;
      WAIT_Z:  if (w_z_hs)    w_state_nxt = OUT;    else w_state_nxt = WAIT_Z;
      OUT:     if (w_res_hs)  w_state_nxt = IDLE;   else w_state_nxt = OUT;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register plus registered per-state decodes so every strobe is a flop.
  // psum_ready stays low through reset and rises on the first edge after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_psum_ready <= 1'b0;
      r_a_stb      <= 1'b0;
      r_b_stb      <= 1'b0;
      r_z_ack      <= 1'b0;
      r_res_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_psum_ready <= (w_state_nxt == IDLE);
      r_a_stb      <= (w_state_nxt == SEND_A);
      r_b_stb      <= (w_state_nxt == SEND_B);
      r_z_ack      <= (w_state_nxt == WAIT_Z);
      r_res_valid  <= (w_state_nxt == OUT);
      r_busy       <= (w_state_nxt != IDLE);
    end
  end

  // Bias register file; writes land in any state without stalling the stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        r_bias[i] <= 32'h0000_0000;
      end
    end else if (bias_wr_en) begin
      r_bias[bias_wr_addr] <= bias_wr_data;
    end
  end

  // Operand latch at psum acceptance; the bias read sees the pre-write value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_add_a <= 32'h0000_0000;
      r_add_b <= 32'h0000_0000;
      r_last  <= 1'b0;
    end else if (w_psum_hs) begin
      r_add_a <= psum_data;
      r_add_b <= r_bias[r_lane];
      r_last  <= psum_last;
    end
  end

  // Result capture from the adder; held stable while waiting for res_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_data <= 32'h0000_0000;
    end else if (w_z_hs) begin
      r_res_data <= w_z_cap;
    end
  end

  // Lane pointer and delivered-element counter advance on each result handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane     <= LANE_ZERO;
      r_elem_cnt <= 16'h0000;
    end else if (w_res_hs) begin
      r_lane     <= r_last ? LANE_ZERO : (r_lane + LANE_ONE);
      r_elem_cnt <= r_elem_cnt + 16'h0001;
    end
  end

  // Sticky NaN flag; a new NaN capture wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nan_seen <= 1'b0;
    end else if (w_z_hs && w_z_nan) begin
      r_nan_seen <= 1'b1;
    end else if (nan_clr) begin
      r_nan_seen <= 1'b0;
    end
  end

  assign psum_ready = r_psum_ready;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_last   = r_last;
  assign add_a      = r_add_a;
  assign add_a_stb  = r_a_stb;
  assign add_b      = r_add_b;
  assign add_b_stb  = r_b_stb;
  assign add_z_ack  = r_z_ack;
  assign busy       = r_busy;
  assign elem_cnt   = r_elem_cnt;
  assign nan_seen   = r_nan_seen;

endmodule
